// File: rtl/board_pkg.sv
// rtl/board_pkg.sv - shared geometry, colors, FSM states and win lines for board_ctl
package board_pkg;

    localparam logic [11:0] H_DIV0_DEF = 12'd338;
    localparam logic [11:0] H_DIV1_DEF = 12'd685;
    localparam logic [11:0] V_DIV0_DEF = 12'd258;
    localparam logic [11:0] V_DIV1_DEF = 12'd507;
    localparam logic [11:0] H_MAX_DEF  = 12'd1023;
    localparam logic [11:0] V_MAX_DEF  = 12'd767;

    localparam logic [11:0] COLOR_BLUE   = 12'h00f;
    localparam logic [11:0] COLOR_YELLOW = 12'hff0;

    typedef enum logic [2:0] {
        IDLE,
        WAIT,
        HIT,
        CHECK,
        OVER
    } board_state_t;

    localparam logic [1:0] WINNER_NONE   = 2'b00;
    localparam logic [1:0] WINNER_BLUE   = 2'b01;
    localparam logic [1:0] WINNER_YELLOW = 2'b10;

    // Zero-based square indices: three rows, three columns, two diagonals.
    localparam logic [3:0] WIN_LINES [8][3] = '{
        '{4'd0, 4'd1, 4'd2},
        '{4'd3, 4'd4, 4'd5},
        '{4'd6, 4'd7, 4'd8},
        '{4'd0, 4'd3, 4'd6},
        '{4'd1, 4'd4, 4'd7},
        '{4'd2, 4'd5, 4'd8},
        '{4'd0, 4'd4, 4'd8},
        '{4'd2, 4'd4, 4'd6}
    };

endpackage

// File: rtl/board_win_check.sv
// rtl/board_win_check.sv - combinational 8-line win test for the mover (built only with BOARD_CTL_WIN_DETECT_EN)
module board_win_check
    import board_pkg::*;
(
    input  logic [8:0] square_occ,
    input  logic [8:0] square_color,
    input  logic       mover,
    output logic       line_win
);

    always_comb begin
        line_win = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (square_occ[WIN_LINES[i][0]] && square_occ[WIN_LINES[i][1]] &&
                square_occ[WIN_LINES[i][2]] &&
                (square_color[WIN_LINES[i][0]] == mover) &&
                (square_color[WIN_LINES[i][1]] == mover) &&
                (square_color[WIN_LINES[i][2]] == mover))
                line_win = 1'b1;
        end
    end

endmodule

// File: rtl/board_ctl.sv
// rtl/board_ctl.sv - tic-tac-toe board state controller; BOARD_CTL_WIN_DETECT_EN enables line-win detection
module board_ctl
    import board_pkg::*;
#(
    parameter logic [11:0] H_DIV0 = H_DIV0_DEF,
    parameter logic [11:0] H_DIV1 = H_DIV1_DEF,
    parameter logic [11:0] V_DIV0 = V_DIV0_DEF,
    parameter logic [11:0] V_DIV1 = V_DIV1_DEF,
    parameter logic [11:0] H_MAX  = H_MAX_DEF,
    parameter logic [11:0] V_MAX  = V_MAX_DEF
) (
    input  logic        pclk,
    input  logic        rst,
    input  logic [11:0] mouse_xpos,
    input  logic [11:0] mouse_ypos,
    input  logic        mouse_left,
    input  logic        start_en,
    input  logic        choice_en,
    output logic [8:0]  square_occ,
    output logic [8:0]  square_color,
    output logic        turn,
    output logic [3:0]  move_cnt,
    output logic        game_over,
    output logic [1:0]  winner
);

    board_state_t state;
    logic         mouse_left_d;
    logic         start_en_d;
    logic [3:0]   idx_q;

    logic         click;
    logic         start_rise;
    logic         start_fall;
    logic         armed;
    logic         in_screen;
    logic [1:0]   col;
    logic [1:0]   row;
    logic [3:0]   hit_idx;
    logic         line_win;

    assign click      = mouse_left && !mouse_left_d;
    assign start_rise = start_en && !start_en_d;
    assign start_fall = !start_en && start_en_d;
    assign armed      = start_en && !choice_en;
    assign in_screen  = (mouse_xpos <= H_MAX) && (mouse_ypos <= V_MAX);

    always_comb begin
        col = 2'd2;
        if (mouse_xpos <= H_DIV0)
            col = 2'd0;
        else if (mouse_xpos <= H_DIV1)
            col = 2'd1;
        row = 2'd2;
        if (mouse_ypos <= V_DIV0)
            row = 2'd0;
        else if (mouse_ypos <= V_DIV1)
            row = 2'd1;
        hit_idx = ({2'b00, row} << 1) + {2'b00, row} + {2'b00, col};
    end

`ifdef BOARD_CTL_WIN_DETECT_EN
    board_win_check u_win_check (
        .square_occ   (square_occ),
        .square_color (square_color),
        .mover        (turn),
        .line_win     (line_win)
    );
`else
    assign line_win = 1'b0;
`endif

    always_ff @(posedge pclk) begin
        if (rst) begin
            state        <= IDLE;
            mouse_left_d <= 1'b0;
            start_en_d   <= 1'b0;
            idx_q        <= 4'd0;
            square_occ   <= 9'd0;
            square_color <= 9'd0;
            turn         <= 1'b0;
            move_cnt     <= 4'd0;
            game_over    <= 1'b0;
            winner       <= WINNER_NONE;
        end else begin
            mouse_left_d <= mouse_left;
            start_en_d   <= start_en;
            // Either start_en edge restarts the board; a coincident click is dropped.
            if (start_rise || start_fall) begin
                state        <= start_rise ? WAIT : IDLE;
                square_occ   <= 9'd0;
                square_color <= 9'd0;
                turn         <= 1'b0;
                move_cnt     <= 4'd0;
                game_over    <= 1'b0;
                winner       <= WINNER_NONE;
            end else begin
                case (state)
                    IDLE: state <= IDLE;
                    WAIT: begin
                        if (click && armed && in_screen) begin
                            idx_q <= hit_idx;
                            state <= HIT;
                        end
                    end
                    HIT: begin
                        if (square_occ[idx_q]) begin
                            state <= WAIT;
                        end else begin
                            square_occ[idx_q]   <= 1'b1;
                            square_color[idx_q] <= turn;
                            if (move_cnt != 4'd9)
                                move_cnt <= move_cnt + 4'd1;
                            state <= CHECK;
                        end
                    end
                    CHECK: begin
                        if (line_win) begin
                            game_over <= 1'b1;
                            winner    <= turn ? WINNER_YELLOW : WINNER_BLUE;
                            state     <= OVER;
                        end else if (move_cnt == 4'd9) begin
                            game_over <= 1'b1;
                            winner    <= WINNER_NONE;
                            state     <= OVER;
                        end else begin
                            turn  <= ~turn;
                            state <= WAIT;
                        end
                    end
                    OVER:    state <= OVER;
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_board_ctl.sv
// tb/tb_board_ctl.sv - scoreboard bench for board_ctl
module tb_board_ctl;

    logic        pclk = 1'b0;
    logic        rst;
    logic [11:0] mouse_xpos;
    logic [11:0] mouse_ypos;
    logic        mouse_left;
    logic        start_en;
    logic        choice_en;
    logic [8:0]  square_occ;
    logic [8:0]  square_color;
    logic        turn;
    logic [3:0]  move_cnt;
    logic        game_over;
    logic [1:0]  winner;

    board_ctl dut (
        .pclk         (pclk),
        .rst          (rst),
        .mouse_xpos   (mouse_xpos),
        .mouse_ypos   (mouse_ypos),
        .mouse_left   (mouse_left),
        .start_en     (start_en),
        .choice_en    (choice_en),
        .square_occ   (square_occ),
        .square_color (square_color),
        .turn         (turn),
        .move_cnt     (move_cnt),
        .game_over    (game_over),
        .winner       (winner)
    );

    always #5 pclk = ~pclk;

`ifdef BOARD_CTL_WIN_DETECT_EN
    localparam bit WIN_EN = 1'b1;
`else
    localparam bit WIN_EN = 1'b0;
`endif

    typedef struct packed {
        logic [8:0] occ;
        logic [8:0] col;
        logic       turn;
        logic [3:0] cnt;
        logic       over;
        logic [1:0] win;
    } snap_t;

    snap_t exp_q[$];

    int n_checks = 0;
    int n_errors = 0;

    logic [8:0] m_occ;
    logic [8:0] m_col;
    logic       m_turn;
    logic [3:0] m_cnt;
    logic       m_over;
    logic [1:0] m_win;

    int win_lines [8][3] = '{
        '{0, 1, 2}, '{3, 4, 5}, '{6, 7, 8},
        '{0, 3, 6}, '{1, 4, 7}, '{2, 5, 8},
        '{0, 4, 8}, '{2, 4, 6}
    };

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic m_clear();
        m_occ  = '0;
        m_col  = '0;
        m_turn = 1'b0;
        m_cnt  = '0;
        m_over = 1'b0;
        m_win  = 2'b00;
    endtask

    task automatic push_snap();
        snap_t s;
        s.occ  = m_occ;
        s.col  = m_col;
        s.turn = m_turn;
        s.cnt  = m_cnt;
        s.over = m_over;
        s.win  = m_win;
        exp_q.push_back(s);
    endtask

    function automatic int square_of(input int x, input int y);
        int c;
        int r;
        if (x > 1023 || y > 767)
            return -1;
        c = (x <= 338) ? 0 : (x <= 685) ? 1 : 2;
        r = (y <= 258) ? 0 : (y <= 507) ? 1 : 2;
        return r * 3 + c;
    endfunction

    function automatic bit mover_has_line(input logic who);
        for (int i = 0; i < 8; i++) begin
            if (m_occ[win_lines[i][0]] && m_occ[win_lines[i][1]] && m_occ[win_lines[i][2]] &&
                m_col[win_lines[i][0]] == who && m_col[win_lines[i][1]] == who &&
                m_col[win_lines[i][2]] == who)
                return 1'b1;
        end
        return 1'b0;
    endfunction

    task automatic model_click(input int x, input int y, input bit blocked);
        int s;
        s = square_of(x, y);
        if (!blocked && !m_over && s >= 0 && !m_occ[s]) begin
            m_occ[s] = 1'b1;
            m_col[s] = m_turn;
            m_cnt    = m_cnt + 4'd1;
            if (WIN_EN && mover_has_line(m_turn)) begin
                m_over = 1'b1;
                m_win  = m_turn ? 2'b10 : 2'b01;
            end else if (m_cnt == 4'd9) begin
                m_over = 1'b1;
                m_win  = 2'b00;
            end else begin
                m_turn = ~m_turn;
            end
        end
        push_snap();
    endtask

    task automatic compare_pop();
        snap_t e;
        check("sb_depth", 32'(exp_q.size()), 32'd1);
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("occ", 32'(square_occ), 32'(e.occ));
            check("color", 32'(square_color), 32'(e.col));
            check("turn", 32'(turn), 32'(e.turn));
            check("move_cnt", 32'(move_cnt), 32'(e.cnt));
            check("game_over", 32'(game_over), 32'(e.over));
            check("winner", 32'(winner), 32'(e.win));
        end
    endtask

    task automatic click(input int x, input int y);
        @(negedge pclk);
        mouse_xpos = 12'(x);
        mouse_ypos = 12'(y);
        mouse_left = 1'b1;
        model_click(x, y, choice_en);
        @(posedge pclk);
        @(negedge pclk);
        mouse_left = 1'b0;
        @(posedge pclk);
        #1;
        check("occ_n2", 32'(square_occ), 32'(exp_q[0].occ));
        check("color_n2", 32'(square_color), 32'(exp_q[0].col));
        @(posedge pclk);
        #1;
        compare_pop();
        repeat (2) @(posedge pclk);
    endtask

    task automatic set_start(input logic v);
        @(negedge pclk);
        if (v != start_en)
            m_clear();
        start_en = v;
        push_snap();
        @(posedge pclk);
        @(posedge pclk);
        #1;
        compare_pop();
    endtask

    task automatic rise_with_click(input int x, input int y);
        @(negedge pclk);
        m_clear();
        push_snap();
        start_en   = 1'b1;
        mouse_xpos = 12'(x);
        mouse_ypos = 12'(y);
        mouse_left = 1'b1;
        @(posedge pclk);
        @(negedge pclk);
        mouse_left = 1'b0;
        repeat (3) @(posedge pclk);
        #1;
        compare_pop();
    endtask

    task automatic reset_in_check(input int x, input int y);
        @(negedge pclk);
        mouse_xpos = 12'(x);
        mouse_ypos = 12'(y);
        mouse_left = 1'b1;
        m_clear();
        push_snap();
        @(posedge pclk);
        @(negedge pclk);
        mouse_left = 1'b0;
        @(posedge pclk);
        @(negedge pclk);
        rst = 1'b1;
        @(posedge pclk);
        #1;
        compare_pop();
        @(negedge pclk);
        rst = 1'b0;
        repeat (2) @(posedge pclk);
    endtask

    initial begin
        rst        = 1'b1;
        mouse_xpos = '0;
        mouse_ypos = '0;
        mouse_left = 1'b0;
        start_en   = 1'b0;
        choice_en  = 1'b0;
        m_clear();
        repeat (3) @(posedge pclk);
        @(negedge pclk);
        rst = 1'b0;
        push_snap();
        @(posedge pclk);
        #1;
        compare_pop();

        set_start(1'b1);
        click(100, 300);
        click(100, 300);
        choice_en = 1'b1;
        click(500, 100);
        choice_en = 1'b0;
        click(1100, 300);
        click(500, 800);

        set_start(1'b0);
        set_start(1'b1);
        click(100, 100);
        click(100, 300);
        click(500, 100);
        click(500, 300);
        click(900, 100);
        click(500, 600);
        click(900, 300);
        click(100, 600);
        click(900, 600);

        set_start(1'b0);
        set_start(1'b1);
        click(100, 100);
        click(500, 100);
        click(900, 100);
        click(500, 300);
        click(100, 300);
        click(900, 300);
        click(500, 600);
        click(100, 600);
        click(900, 600);
        click(338, 258);

        set_start(1'b0);
        rise_with_click(100, 100);
        click(338, 259);
        click(339, 507);

        reset_in_check(900, 600);
        m_clear();
        click(500, 300);
        click(1023, 767);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/board_ctl.md
# board_ctl

Tic-tac-toe board state controller: converts mouse clicks into square ownership for the nine on-screen squares. It sits upstream of the `draw_squareN` overlay stages and drives their `squareN` / `squareN_color` inputs. It tracks the player turn and detects win and draw conditions. It runs in the `pclk` domain, alongside the VGA timing chain.

## Interface
Parameters:
- `H_DIV0`, default 338: last x pixel of column 0.
- `H_DIV1`, default 685: last x pixel of column 1.
- `V_DIV0`, default 258: last y pixel of row 0.
- `V_DIV1`, default 507: last y pixel of row 1.
- `H_MAX`, default 1023: last visible x.
- `V_MAX`, default 767: last visible y.

Ports:
- `pclk`  in  1  pixel clock.
- `rst`  in  1  reset, synchronous, active-high.
- `mouse_xpos`  in  12  cursor x, `pclk` domain.
- `mouse_ypos`  in  12  cursor y, `pclk` domain.
- `mouse_left`  in  1  left button level.
- `start_en`  in  1  game screen active.
- `choice_en`  in  1  choice/menu overlay active; clicks are blocked while high.
- `square_occ`  out  9  bit i set = square i+1 occupied.
- `square_color`  out  9  bit i = owner of square i+1 (0 blue, 1 yellow); feeds `squareN_color` (0 → BLUE 12'h00f, else YELLOW 12'hff0).
- `turn`  out  1  player to move (0 blue, 1 yellow).
- `move_cnt`  out  4  accepted moves, 0..9.
- `game_over`  out  1  win or draw reached.
- `winner`  out  2  00 none/draw, 01 blue, 10 yellow.

## Operation
- Squares are numbered 1..9 row-major. Column: x≤H_DIV0 → 0; x≤H_DIV1 → 1; x≤H_MAX → 2. Row uses V_DIV0/V_DIV1/V_MAX the same way. Index = 3·row + col. Square 4 = row 1, col 0 = x≤338, 259≤y≤507.
- A click is the rising edge of `mouse_left`: current high, registered previous low.
- `armed` = `start_en` && !`choice_en`.
- FSM states:
  - IDLE: board cleared. Go to WAIT on a `start_en` rising edge.
  - WAIT: on click && `armed` && in-screen → register index, go to HIT. Otherwise stay in WAIT.
  - HIT: if square occupied → return to WAIT, no change. Else set `square_occ[idx]`, set `square_color[idx]`=`turn`, increment `move_cnt`, go to CHECK.
  - CHECK: evaluate 8 lines.
    - Line owned by the mover → `game_over`=1, `winner`=mover, go to OVER.
    - Else `move_cnt`==9 → `game_over`=1, `winner`=00, go to OVER.
    - Else toggle `turn`, go to WAIT.
  - OVER: ignore clicks. A `start_en` rising edge clears the board and goes to WAIT.
- `start_en` falling edge in any state → IDLE, board cleared.
- Out-of-screen clicks (x>H_MAX or y>V_MAX) are dropped.
- A click that arrives during HIT/CHECK is dropped. There is no queueing.
- If a `start_en` rising edge and a click occur in the same cycle, the clear wins and the click is dropped.
- Compare arithmetic is 12-bit unsigned. `move_cnt` saturates at 9.

## Timing
- Reset value of every output is 0. State = IDLE. Edge-detect registers = 0.
- A click seen in cycle N (WAIT): the `square_occ`/`square_color` bit is visible at N+2. `turn`/`game_over`/`winner` update at N+3.
- WAIT is re-entered at N+2 (occupied square) or at N+3 (accepted move, no end).
- A clear takes effect on outputs one cycle after the `start_en` edge cycle.
- Reset mid-operation (any state) → all outputs 0 next cycle, state IDLE.

## Configuration
- `BOARD_CTL_WIN_DETECT_EN` defined:
  - CHECK performs the 8-line win test as above.
- Not defined:
  - Line test is removed.
  - `game_over` asserts only when `move_cnt` reaches 9.
  - `winner` is tied to 00.
  - `turn` still alternates.

## Structure
- Package `board_pkg`:
  - geometry defaults (338/685/258/507/1023/767);
  - color constants BLUE 12'h00f, YELLOW 12'hff0;
  - FSM state typedef (IDLE, WAIT, HIT, CHECK, OVER);
  - `winner` encodings;
  - 8 win-line index triples.
- Sub-module `board_win_check`: combinational.
  - Inputs: `square_occ`, `square_color`, mover.
  - Output: `line_win`.
  - Excluded from the build when the macro is off.

## Test plan
- Reset, then `start_en` 0→1, click at (100,300) → `square_occ`=9'b000001000 at N+2, `square_color[3]`=0, `turn`=1 at N+3, `move_cnt`=1.
- Second click on the same square (100,300) → outputs unchanged, `turn` stays 1, `move_cnt` stays 1.
- Blue plays squares 1,2,3 (e.g. (100,100),(500,100),(900,100)); yellow plays 4,5 → after the third blue move, `game_over`=1, `winner`=01, and a following click at (500,600) is ignored.
- Nine alternating moves with no line (order 1,2,3,5,4,6,8,7,9) → `move_cnt`=9, `game_over`=1, `winner`=00. Without the macro, the blue 1-2-3 scenario keeps playing until the board is full.
- Click with `choice_en`=1, or at (1100,300) → no state change.
- `start_en` rising edge coincident with a click; also `rst` asserted during CHECK → board cleared, all outputs 0, no move recorded.
